// File: rtl/adder_seq_pkg.sv
// Shared constants and state encoding for the chunked sequential adder.
package adder_seq_pkg;

  // Width of the single shared adder slice; operands are streamed through it LSB chunk first.
  localparam int CHUNK = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/adder_select_16_bit_ci.sv
// Combinational 16-bit carry-select adder with carry-in.
// The low byte ripples from ci. The high byte is precomputed for both possible carries.
// The low byte's carry then picks one of the two precomputed results.
module adder_select_16_bit_ci
  import adder_seq_pkg::*;
(
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  localparam int HALF = CHUNK / 2;

  logic [HALF:0] lo_sum;
  logic [HALF:0] hi_sum_c0;
  logic [HALF:0] hi_sum_c1;

  assign lo_sum    = {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]} + {{HALF{1'b0}}, ci};
  assign hi_sum_c0 = {1'b0, a[CHUNK-1:HALF]} + {1'b0, b[CHUNK-1:HALF]};
  assign hi_sum_c1 = {1'b0, a[CHUNK-1:HALF]} + {1'b0, b[CHUNK-1:HALF]} + {{HALF{1'b0}}, 1'b1};

  assign s  = {(lo_sum[HALF] ? hi_sum_c1[HALF-1:0] : hi_sum_c0[HALF-1:0]), lo_sum[HALF-1:0]};
  assign co = lo_sum[HALF] ? hi_sum_c1[HALF] : hi_sum_c0[HALF];

endmodule

// File: rtl/adder_select_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder: streams CHUNK-bit slices, LSB first, through one shared
// carry-select adder, chaining the carry in a register. Valid/ready on both sides.
module adder_select_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (((WIDTH % CHUNK) != 0) || (NCHUNK < 2)) begin : g_bad_width
    $error("adder_select_seq_ctrl: WIDTH must be a multiple of CHUNK with at least two chunks");
  end

  seq_state_e       state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co;

  logic             accept;

  assign accept  = in_valid && in_ready;
  assign busy    = (state == RUN) || (state == DONE);
  assign chunk_a = a_q[idx*CHUNK +: CHUNK];
  assign chunk_b = b_q[idx*CHUNK +: CHUNK];

  adder_select_16_bit_ci u_chunk_adder (
    .a  (chunk_a),
    .b  (chunk_b),
    .ci (carry_q),
    .s  (chunk_s),
    .co (chunk_co)
  );

  // Operand holding registers: pure data, loaded only on the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Sequencer: accept, walk the chunks LSB first, hold the result until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_q   <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            carry_q  <= cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          s[idx*CHUNK +: CHUNK] <= chunk_s;
          carry_q               <= chunk_co;
          if (idx == LAST_IDX) begin
            // idx parks on the last chunk; it is cleared again on the next accept.
            cout      <= chunk_co;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // No same-cycle accept here: in_ready only rises once the block is back in IDLE.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_select_seq_ctrl.sv
// Bench for adder_select_seq_ctrl (WIDTH=64): directed vectors, backpressure, mid-op reset,
// back-to-back random traffic, with a queue of expected {cout,s} values.
module tb_adder_select_seq_ctrl;

  localparam int WIDTH = 64;
  localparam int NOPS  = 1000;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH:0] sb_q[$];

  adder_select_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH:0] model_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  function automatic logic [WIDTH-1:0] rand64();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '1;
      1:       v = '0;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    step();
    step();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (s !== '0) begin failures++; $display("FAIL reset_s got=%h exp=0", s); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [WIDTH-1:0] va[4];
    logic [WIDTH-1:0] vb[4];
    logic             vc[4];
    logic [WIDTH:0]   exp;
    int               lat;
    va[0] = 64'h0000_0000_0000_FFFF; vb[0] = 64'h1;                   vc[0] = 1'b0;
    va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'h0;                   vc[1] = 1'b1;
    va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'h8000_0000_0000_0000; vc[2] = 1'b0;
    va[3] = 64'h7FFF_FFFF_FFFF_FFFF; vb[3] = 64'h7FFF_FFFF_FFFF_FFFF; vc[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL vec%0d_in_ready got=%b exp=1", i, in_ready); end
      a = va[i]; b = vb[i]; cin = vc[i];
      sb_q.push_back(model_sum(va[i], vb[i], vc[i]));
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
        step();
        lat++;
      end
      checks++; if (lat != 4) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=4", i, lat); end
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
      checks++; if ({cout, s} !== exp) begin failures++; $display("FAIL vec%0d_sum got=%h exp=%h", i, {cout, s}, exp); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL vec%0d_drain got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH:0] exp;
    int             lat;
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; cin = 1'b1;
    exp = model_sum(a, b, cin);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    checks++; if (lat != 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    in_valid = 1'b1; a = '1; b = '1; cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid%0d got=%b exp=1", i, out_valid); end
      checks++; if ({cout, s} !== exp) begin failures++; $display("FAIL bp_hold_sum%0d got=%h exp=%h", i, {cout, s}, exp); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready%0d got=%b exp=0", i, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_ignored_input busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    a = '1; b = 64'h1; cin = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy got=%b exp=1", busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    checks++; if (s !== '0) begin failures++; $display("FAIL midrst_s got=%h exp=0", s); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL midrst_cout got=%b exp=0", cout); end
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    out_ready = 1'b0;
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_ghost_result got=%b exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH:0] exp;
    int accepted, done, cyc, last_out;
    bit took;
    accepted = 0; done = 0; cyc = 0; last_out = -1;
    sb_q.delete();
    a = rand64(); b = rand64(); cin = 1'($urandom_range(0, 1));
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (done < NOPS && cyc < NOPS * 6 + 50) begin
      took = 1'b0;
      if (out_valid === 1'b1) begin
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        checks++; if ({cout, s} !== exp) begin failures++; $display("FAIL b2b_sum%0d got=%h exp=%h", done, {cout, s}, exp); end
        if (last_out >= 0) begin
          checks++; if (cyc - last_out != 6) begin failures++; $display("FAIL b2b_spacing%0d got=%0d exp=6", done, cyc - last_out); end
        end
        last_out = cyc;
        done++;
      end
      if (in_ready === 1'b1 && accepted < NOPS) begin
        sb_q.push_back(model_sum(a, b, cin));
        accepted++;
        took = 1'b1;
      end
      step();
      cyc++;
      if (took) begin
        if (accepted == NOPS) in_valid = 1'b0;
        else begin
          a = rand64(); b = rand64(); cin = 1'($urandom_range(0, 1));
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (done != NOPS) begin failures++; $display("FAIL b2b_timeout got=%0d exp=%0d", done, NOPS); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
